// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU operation classes,
// ALU codes, opcodes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } ALUOp_t;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_SRL   = 4'd7;
  localparam logic [3:0] ALU_SRA   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format follows the opcode alone, so the extender is set up in every state.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and status in, mux selects and strobes out.
interface mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       MemReq;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal
  );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's operation class plus instruction fields to an ALU code.
module mc_aludec
  import mc_pkg::*;
(
  input  ALUOp_t     alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  input  logic       is_lui,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        if (is_lui) begin
          alu_control = ALU_PASSB;
        end else begin
          case (funct3)
            // IR[30] is an immediate bit for addi, so only R-type may select SUB.
            3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b011:  alu_control = ALU_SLTU;
            3'b100:  alu_control = ALU_XOR;
            3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_control = ALU_OR;
            default: alu_control = ALU_AND;
          endcase
        end
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V main controller: Moore FSM sharing one ALU and one unified memory port
// across FETCH/DECODE/EXECUTE/MEM/WB; memory states hold until MemReady.
module mc_controller
  import mc_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  state_t     state;
  state_t     state_next;
  ALUOp_t     alu_op;
  logic       mem_req;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       illegal;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = bus.MemReady;
        pc_write   = bus.MemReady;
        if (bus.MemReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute OldPC+imm so BRANCH/JAL find their target already in ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE, OP_LUI:  state_next = S_EXECI;
          OP_BRANCH:         state_next = (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (bus.MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (bus.MemReady) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = bus.funct3[0] ? ~bus.Zero : bus.Zero;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_TRAP: begin
        illegal    = 1'b1;
        state_next = S_TRAP;
      end
      default: state_next = S_FETCH;
    endcase
  end

  mc_aludec u_aludec (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .is_lui      (bus.op == OP_LUI),
    .alu_control (bus.ALUControl)
  );

  // Strobes are gated by reset directly so a pending memory request dies in the reset cycle.
  assign bus.MemReq    = mem_req   & ~reset;
  assign bus.MemWrite  = mem_write & ~reset;
  assign bus.IRWrite   = ir_write  & ~reset;
  assign bus.PCWrite   = pc_write  & ~reset;
  assign bus.RegWrite  = reg_write & ~reset;
  assign bus.Illegal   = illegal   & ~reset;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ImmSrc    = imm_src_of(bus.op);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed scenarios plus random instruction streams checked
// against per-instruction phase lists and CPI counts.
module tb_mc_controller;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_JAL, P_TRAP} ph_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] res_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       illegal;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic zero_val = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   hold_cnt = 0;
  bit   rnd_ready = 1'b0;

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    if (op == 7'b0110111) return 4'd10;
    case (f3)
      3'd0:    return (op == 7'b0110011 && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd6;
      3'd2:    return 4'd5;
      3'd3:    return 4'd9;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd8 : 4'd7;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic obs_t sample();
    return {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.Illegal};
  endfunction

  task automatic check(input obs_t o, input obs_t e, input obs_t m, input string tag);
    tests++;
    assert ((o & m) === (e & m)) else begin
      fails++;
      $error("FAIL %s: observed %h required %h (mask %h)", tag, o & m, e & m, m);
    end
  endtask

  // One clock in phase ph; entered just after a falling edge, leaves after the next one.
  task automatic step(input ph_t ph, input logic mr, input string tag);
    obs_t e, m;
    bus.MemReady = mr;
    bus.Zero     = zero_val;
    #1;
    e = '0;
    m = '0;
    {m.mem_req, m.mem_write, m.ir_write, m.pc_write, m.reg_write, m.illegal} = '1;
    m.alu = '1;
    m.imm = '1;
    case (bus.op)
      7'b0000011, 7'b0010011: e.imm = 3'd0;
      7'b0100011: e.imm = 3'd1;
      7'b1100011: e.imm = 3'd2;
      7'b1101111: e.imm = 3'd3;
      7'b0110111: e.imm = 3'd4;
      default:    m.imm = '0;
    endcase
    case (ph)
      P_FETCH: begin
        e.mem_req = 1; e.ir_write = mr; e.pc_write = mr;
        e.res_src = 2'b10; e.src_b = 2'b10;
        m.adr_src = 1; m.res_src = '1; m.src_a = '1; m.src_b = '1;
      end
      P_DECODE: begin
        e.src_a = 2'b01; e.src_b = 2'b01; m.src_a = '1; m.src_b = '1;
      end
      P_MEMADR: begin
        e.src_a = 2'b10; e.src_b = 2'b01; m.src_a = '1; m.src_b = '1;
      end
      P_MEMREAD: begin
        e.mem_req = 1; e.adr_src = 1; m.adr_src = 1; m.res_src = '1;
      end
      P_MEMWB: begin
        e.res_src = 2'b01; e.reg_write = 1; m.res_src = '1;
      end
      P_MEMWRITE: begin
        e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; m.adr_src = 1; m.res_src = '1;
      end
      P_EXECR, P_EXECI: begin
        e.src_a = 2'b10; e.src_b = (ph == P_EXECI) ? 2'b01 : 2'b00;
        e.alu = exp_alu(bus.op, bus.funct3, bus.funct7b5);
        m.src_a = '1; m.src_b = '1;
      end
      P_ALUWB: begin
        e.reg_write = 1; m.res_src = '1;
      end
      P_BRANCH: begin
        e.src_a = 2'b10; e.alu = 4'd1;
        e.pc_write = bus.funct3[0] ? ~zero_val : zero_val;
        m.src_a = '1; m.src_b = '1; m.res_src = '1;
      end
      P_JAL: begin
        e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1;
        m.src_a = '1; m.src_b = '1; m.res_src = '1;
      end
      default: begin
        e.illegal = 1;
        m.alu = '0;
      end
    endcase
    check(sample(), e, m, tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one instruction from FETCH back to FETCH and checks its cycle count.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int zmode, input string tag);
    ph_t q[$];
    int  cpi, idx, cycles, waits;
    logic mr;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
    q = '{P_FETCH, P_DECODE};
    case (op)
      7'b0110011: begin q.push_back(P_EXECR); q.push_back(P_ALUWB); cpi = 4; end
      7'b0010011, 7'b0110111: begin q.push_back(P_EXECI); q.push_back(P_ALUWB); cpi = 4; end
      7'b0000011: begin q.push_back(P_MEMADR); q.push_back(P_MEMREAD); q.push_back(P_MEMWB); cpi = 5; end
      7'b0100011: begin q.push_back(P_MEMADR); q.push_back(P_MEMWRITE); cpi = 4; end
      7'b1100011: begin q.push_back(P_BRANCH); cpi = 3; end
      default:    begin q.push_back(P_JAL); q.push_back(P_ALUWB); cpi = 4; end
    endcase
    idx = 0; cycles = 0; waits = 0;
    while (idx < q.size() && cycles < 100) begin
      if ((q[idx] == P_MEMREAD || q[idx] == P_MEMWRITE) && hold_cnt > 0) begin
        mr = 1'b0;
        hold_cnt--;
      end else if (rnd_ready) begin
        mr = ($urandom_range(0, 9) < 6);
      end else begin
        mr = 1'b1;
      end
      zero_val = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      step(q[idx], mr, tag);
      cycles++;
      if ((q[idx] == P_FETCH || q[idx] == P_MEMREAD || q[idx] == P_MEMWRITE) && !mr) waits++;
      else idx++;
    end
    tests++;
    assert (cycles === cpi + waits && idx == q.size()) else begin
      fails++;
      $error("FAIL %s_cycles: observed %0d required %0d", tag, cycles, cpi + waits);
    end
  endtask

  initial begin
    obs_t o;
    bus.op = 7'b0010011; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0; bus.MemReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    o = sample();
    tests++;
    assert (o.mem_req === 0 && o.mem_write === 0 && o.ir_write === 0 && o.pc_write === 0 &&
            o.reg_write === 0 && o.illegal === 0) else begin
      fails++;
      $error("FAIL reset_strobes: observed %h required 0 strobes", o);
    end
    reset = 1'b0;

    // addi x1,x0,5 (0x00500093)
    run_instr(7'b0010011, 3'd0, 1'b0, 0, "addi");
    run_instr(7'b0110011, 3'd0, 1'b1, 0, "sub");
    run_instr(7'b0010011, 3'd0, 1'b1, 0, "addi_imm10");
    run_instr(7'b0010011, 3'd5, 1'b1, 0, "srai");
    run_instr(7'b0010011, 3'd5, 1'b0, 0, "srli");
    run_instr(7'b0110111, 3'd3, 1'b1, 0, "lui");
    hold_cnt = 3;
    run_instr(7'b0000011, 3'd2, 1'b0, 0, "lw_wait3");
    run_instr(7'b0100011, 3'd2, 1'b0, 0, "sw");
    run_instr(7'b1100011, 3'd0, 1'b0, 1, "beq_taken");
    run_instr(7'b1100011, 3'd0, 1'b0, 0, "beq_not");
    run_instr(7'b1100011, 3'd1, 1'b0, 1, "bne_not");
    run_instr(7'b1100011, 3'd1, 1'b0, 0, "bne_taken");
    run_instr(7'b1101111, 3'd0, 1'b0, 0, "jal");

    rnd_ready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = 7'b0110111;
        3: op = 7'b0000011;
        4: op = 7'b0100011;
        5: begin op = 7'b1100011; f3 = {2'b00, f3[0]}; end
        6: op = 7'b1101111;
        default: op = 7'b0010011;
      endcase
      if ($urandom_range(0, 3) == 0) hold_cnt = $urandom_range(1, 4);
      run_instr(op, f3, 1'($urandom_range(0, 1)), 2, "rand");
    end
    rnd_ready = 1'b0;
    hold_cnt = 0;

    // Unsupported opcode: terminal TRAP with no strobes, cleared only by reset.
    bus.op = 7'h7F; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
    step(P_FETCH, 1'b1, "trap_fetch");
    step(P_DECODE, 1'b1, "trap_decode");
    for (int n = 0; n < 10; n++) step(P_TRAP, 1'($urandom_range(0, 1)), "trap_hold");
    reset = 1'b1;
    #1;
    tests++;
    assert (bus.Illegal === 1'b0 && bus.MemReq === 1'b0) else begin
      fails++;
      $error("FAIL trap_reset: observed Illegal=%b MemReq=%b required 0/0", bus.Illegal, bus.MemReq);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(P_FETCH, 1'b0, "trap_release_fetch");
    run_instr(7'b0010011, 3'd4, 1'b0, 0, "xori_after_trap");

    // Reset in the middle of a stalled store.
    bus.op = 7'b0100011; bus.funct3 = 3'd2; bus.funct7b5 = 1'b0;
    step(P_FETCH, 1'b1, "swr_fetch");
    step(P_DECODE, 1'b1, "swr_decode");
    step(P_MEMADR, 1'b1, "swr_memadr");
    step(P_MEMWRITE, 1'b0, "swr_stall");
    bus.MemReady = 1'b0;
    #1;
    tests++;
    assert (bus.MemReq === 1'b1 && bus.MemWrite === 1'b1) else begin
      fails++;
      $error("FAIL swr_pending: observed MemReq=%b MemWrite=%b required 1/1", bus.MemReq, bus.MemWrite);
    end
    reset = 1'b1;
    #1;
    tests++;
    assert (bus.MemReq === 1'b0 && bus.MemWrite === 1'b0) else begin
      fails++;
      $error("FAIL swr_reset_drop: observed MemReq=%b MemWrite=%b required 0/0", bus.MemReq, bus.MemWrite);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(P_FETCH, 1'b0, "swr_release_fetch");
    run_instr(7'b0110011, 3'd7, 1'b0, 0, "and_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
